// File: rtl/tlk2711_tx_cmd_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tlk2711_tx_cmd_gen
//  Description : TX DMA read-command generator for the TLK2711 transmit path.
//                Splits each frame into body reads plus an optional tail read,
//                repeats frames (fixed count or continuous), limits in-flight
//                reads with credits and reports frame/job completion.
//  Revision    : 1.0 - initial release
// ============================================================================
module tlk2711_tx_cmd_gen #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DLEN_WIDTH      = 16,
  parameter int CNT_WIDTH       = 16,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_soft_rst,
  input  logic                             i_tx_start,
  input  logic                             i_tx_stop,
  input  logic [ADDR_WIDTH-1:0]            i_tx_base_addr,
  input  logic [DLEN_WIDTH-1:0]            i_tx_packet_body,
  input  logic [DLEN_WIDTH-1:0]            i_tx_packet_tail,
  input  logic [DLEN_WIDTH-1:0]            i_tx_stride,
  input  logic [CNT_WIDTH-1:0]             i_tx_body_num,
  input  logic [CNT_WIDTH-1:0]             i_tx_loop_num,
  output logic                             o_rd_cmd_req,
  input  logic                             i_rd_cmd_ack,
  output logic [DLEN_WIDTH+ADDR_WIDTH-1:0] o_rd_cmd_data,
  input  logic                             i_dma_rd_last,
  output logic                             o_busy,
  output logic                             o_frame_done,
  output logic                             o_tx_done,
  output logic [CNT_WIDTH-1:0]             o_frame_cnt,
  output logic                             o_err
);

  // Outstanding counter must hold 0..MAX_OUTSTANDING inclusive.
  localparam int OS_WIDTH  = $clog2(MAX_OUTSTANDING + 1);
  // Commands per frame can be body_num + 1, so one extra bit.
  localparam int CPF_WIDTH = CNT_WIDTH + 1;
  localparam logic [OS_WIDTH-1:0]  OS_MAX  = OS_WIDTH'(MAX_OUTSTANDING);
  localparam logic [CPF_WIDTH-1:0] CPF_ONE = CPF_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  // Configuration latched on an accepted start
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [DLEN_WIDTH-1:0] body_len;
  logic [DLEN_WIDTH-1:0] tail_len;
  logic [DLEN_WIDTH-1:0] step;
  logic [CNT_WIDTH-1:0]  body_num;
  logic [CNT_WIDTH-1:0]  loop_num;
  logic [CPF_WIDTH-1:0]  cpf;

  // Issue / completion bookkeeping
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [CPF_WIDTH-1:0]  issue_idx;
  logic [CPF_WIDTH-1:0]  comp_idx;
  logic [CNT_WIDTH-1:0]  frames_issued;
  logic [OS_WIDTH-1:0]   outstanding;
  logic                  stop_pending;
  logic                  ignore_last;
  logic                  frame_done_q;
  logic                  err_q;
  logic [CNT_WIDTH-1:0]  frame_cnt;

  // Combinational helpers
  logic                  tail_nz;
  logic [CPF_WIDTH-1:0]  start_cpf;
  logic [CPF_WIDTH-1:0]  cpf_m1;
  logic                  accept;
  logic                  last_of_frame;
  logic                  end_of_job;
  logic                  rd_valid;
  logic                  rd_spurious;
  logic [DLEN_WIDTH-1:0] cmd_len;

  assign tail_nz       = (i_tx_packet_tail != '0);
  assign start_cpf     = {1'b0, i_tx_body_num} + {{CNT_WIDTH{1'b0}}, tail_nz};
  assign cpf_m1        = cpf - CPF_ONE;
  assign accept        = o_rd_cmd_req & i_rd_cmd_ack;
  assign last_of_frame = (issue_idx == cpf_m1);
  // A frame boundary ends the job on a stop request or when the loop count is reached.
  assign end_of_job    = stop_pending | i_tx_stop |
                         ((loop_num != '0) && ((frames_issued + CNT_ONE) == loop_num));
  assign rd_valid      = i_dma_rd_last & (outstanding != '0);
  // Late completions of an aborted job are swallowed silently while idle.
  assign rd_spurious   = i_dma_rd_last & (outstanding == '0) &
                         ~((state == ST_IDLE) & ignore_last);
  assign cmd_len       = (issue_idx < {1'b0, body_num}) ? body_len : tail_len;

  assign o_rd_cmd_data = {cur_addr, cmd_len};
  assign o_busy        = (state != ST_IDLE);
  assign o_frame_done  = frame_done_q;
  assign o_err         = err_q;
  assign o_frame_cnt   = frame_cnt;

  // State register; both resets return to idle
  always_ff @(posedge clk) begin
    if (rst || i_soft_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic, command request and job-done strobe
  always_comb begin
    state_nxt    = state;
    o_rd_cmd_req = 1'b0;
    o_tx_done    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (i_tx_start && (start_cpf != '0)) begin
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        o_rd_cmd_req = (outstanding < OS_MAX);
        if (accept && last_of_frame && end_of_job) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (outstanding == '0) begin
          o_tx_done = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Config latch, address accumulation, credit counter and completion tracking
  always_ff @(posedge clk) begin
    if (rst || i_soft_rst) begin
      base_addr     <= '0;
      body_len      <= '0;
      tail_len      <= '0;
      step          <= '0;
      body_num      <= '0;
      loop_num      <= '0;
      cpf           <= '0;
      cur_addr      <= '0;
      issue_idx     <= '0;
      comp_idx      <= '0;
      frames_issued <= '0;
      outstanding   <= '0;
      stop_pending  <= 1'b0;
      ignore_last   <= 1'b1;
      frame_done_q  <= 1'b0;
      err_q         <= 1'b0;
      frame_cnt     <= '0;
    end else begin
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;

      if ((state == ST_IDLE) && i_tx_start) begin
        ignore_last <= 1'b0;
        if (start_cpf == '0) begin
          err_q <= 1'b1;
        end else begin
          base_addr     <= i_tx_base_addr;
          body_len      <= i_tx_packet_body;
          tail_len      <= i_tx_packet_tail;
          step          <= (i_tx_stride == '0) ? i_tx_packet_body : i_tx_stride;
          body_num      <= i_tx_body_num;
          loop_num      <= i_tx_loop_num;
          cpf           <= start_cpf;
          cur_addr      <= i_tx_base_addr;
          issue_idx     <= '0;
          comp_idx      <= '0;
          frames_issued <= '0;
          frame_cnt     <= '0;
          stop_pending  <= 1'b0;
        end
      end

      if ((state == ST_ISSUE) && i_tx_stop) begin
        stop_pending <= 1'b1;
      end

      // Each frame restarts at the base address; otherwise step forward.
      if (accept) begin
        if (last_of_frame) begin
          cur_addr      <= base_addr;
          issue_idx     <= '0;
          frames_issued <= frames_issued + CNT_ONE;
        end else begin
          cur_addr  <= cur_addr + ADDR_WIDTH'(step);
          issue_idx <= issue_idx + CPF_ONE;
        end
      end

      case ({accept, rd_valid})
        2'b10:   outstanding <= outstanding + OS_WIDTH'(1);
        2'b01:   outstanding <= outstanding - OS_WIDTH'(1);
        default: outstanding <= outstanding;
      endcase

      if (rd_spurious) begin
        err_q <= 1'b1;
      end

      if (rd_valid) begin
        if (comp_idx == cpf_m1) begin
          comp_idx     <= '0;
          frame_done_q <= 1'b1;
          frame_cnt    <= frame_cnt + CNT_ONE;
        end else begin
          comp_idx <= comp_idx + CPF_ONE;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tlk2711_tx_cmd_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tlk2711_tx_cmd_gen
//  Description : Self-checking bench; two DUT lanes (credit limits 2 and 1)
//                share stimulus and are each compared against a per-lane
//                command-count reference model every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tlk2711_tx_cmd_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        soft_rst = 1'b0;
  logic        tx_start = 1'b0;
  logic        tx_stop = 1'b0;
  logic [31:0] cfg_base = '0;
  logic [15:0] cfg_body = '0;
  logic [15:0] cfg_tail = '0;
  logic [15:0] cfg_stride = '0;
  logic [15:0] cfg_bnum = '0;
  logic [15:0] cfg_loop = '0;
  bit          inject = 1'b0;
  bit          chk_en = 1'b0;
  int          ack_max = 0;
  int          lat_min = 1;
  int          lat_max = 4;
  int          n_checks = 0;
  int          n_fails = 0;

  localparam longint INF = longint'(1) << 40;

  always #5 clk = ~clk;

  task automatic check(input string name, input int lane, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s lane%0d: actual=%0h required=%0h (t=%0t)", name, lane, act, exp, $time);
    end
  endtask

  // Command n of a job, straight from the addressing rules.
  function automatic logic [47:0] cmd_word(input longint n, input int cpf_v,
                                           input logic [31:0] base, input logic [15:0] body,
                                           input logic [15:0] tail, input logic [15:0] stride,
                                           input logic [15:0] bnum);
    longint      j = n % cpf_v;
    logic [31:0] s = (stride == 16'd0) ? {16'd0, body} : {16'd0, stride};
    logic [31:0] k = (j < bnum) ? 32'(j) : {16'd0, bnum};
    logic [31:0] a = base + k * s;
    return {a, (j < bnum) ? body : tail};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_lane
    localparam int MAXO = 2 - g;

    logic        req, busy, fdone, tdone, err;
    logic        ack = 1'b0;
    logic        rd_last = 1'b0;
    logic [47:0] data;
    logic [15:0] fcnt;

    bit          active = 1'b0;
    bit          was_active = 1'b0;
    bit          ignore_last = 1'b1;
    bit          m_fdone = 1'b0;
    bit          m_err = 1'b0;
    bit          e_req = 1'b0;
    bit          e_tdone = 1'b0;
    longint      n_iss = 0;
    longint      n_cmp = 0;
    longint      n_tot = 0;
    longint      iss0 = 0;
    longint      lim = 0;
    int          cpf = 1;
    int          new_cpf = 0;
    int          lane_cyc = 0;
    int          ack_wait = 0;
    int          last_due = 0;
    int          due;
    logic [31:0] l_base = '0;
    logic [15:0] l_body = '0, l_tail = '0, l_stride = '0, l_bnum = '0;
    logic [47:0] exp_data = '0;
    int          due_q[$];
    logic [47:0] acc_log[$];

    tlk2711_tx_cmd_gen #(
      .ADDR_WIDTH(32), .DLEN_WIDTH(16), .CNT_WIDTH(16), .MAX_OUTSTANDING(MAXO)
    ) dut (
      .clk(clk), .rst(rst), .i_soft_rst(soft_rst), .i_tx_start(tx_start), .i_tx_stop(tx_stop),
      .i_tx_base_addr(cfg_base), .i_tx_packet_body(cfg_body), .i_tx_packet_tail(cfg_tail),
      .i_tx_stride(cfg_stride), .i_tx_body_num(cfg_bnum), .i_tx_loop_num(cfg_loop),
      .o_rd_cmd_req(req), .i_rd_cmd_ack(ack), .o_rd_cmd_data(data), .i_dma_rd_last(rd_last),
      .o_busy(busy), .o_frame_done(fdone), .o_tx_done(tdone), .o_frame_cnt(fcnt), .o_err(err)
    );

    // Model update at the clock edge, then compare and respond at the falling edge.
    always begin
      @(posedge clk);
      lane_cyc++;
      was_active = active;
      m_fdone = 1'b0;
      m_err = 1'b0;
      if (rst || soft_rst) begin
        active = 1'b0; ignore_last = 1'b1; n_iss = 0; n_cmp = 0; n_tot = 0; cpf = 1;
      end else begin
        iss0 = n_iss;
        if (rd_last) begin
          if (n_iss == n_cmp) begin
            if (was_active || !ignore_last) m_err = 1'b1;
          end else begin
            n_cmp++;
            if (n_cmp % cpf == 0) m_fdone = 1'b1;
          end
        end
        if (e_req && ack) begin
          n_iss++;
          due = lane_cyc + $urandom_range(lat_max, lat_min);
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          due_q.push_back(due);
        end
        if (was_active && tx_stop) begin
          lim = (iss0 / cpf + 1) * cpf;
          if (lim < n_tot) n_tot = lim;
        end
        if (e_tdone) active = 1'b0;
        if (!was_active && tx_start) begin
          ignore_last = 1'b0;
          new_cpf = int'(cfg_bnum) + ((cfg_tail != 16'd0) ? 1 : 0);
          if (new_cpf == 0) m_err = 1'b1;
          else begin
            cpf = new_cpf; active = 1'b1; n_iss = 0; n_cmp = 0;
            n_tot = (cfg_loop != 16'd0) ? longint'(cfg_loop) * cpf : INF;
            l_base = cfg_base; l_body = cfg_body; l_tail = cfg_tail;
            l_stride = cfg_stride; l_bnum = cfg_bnum;
          end
        end
      end
      e_req = active && (n_iss < n_tot) && ((n_iss - n_cmp) < MAXO);
      e_tdone = active && (n_iss == n_tot) && (n_cmp == n_tot);
      exp_data = cmd_word(n_iss, cpf, l_base, l_body, l_tail, l_stride, l_bnum);

      @(negedge clk);
      if (chk_en) begin
        check("busy", g, 64'(busy), 64'(active));
        check("req", g, 64'(req), 64'(e_req));
        if (e_req) check("cmd_data", g, 64'(data), 64'(exp_data));
        check("frame_done", g, 64'(fdone), 64'(m_fdone));
        check("tx_done", g, 64'(tdone), 64'(e_tdone));
        check("err", g, 64'(err), 64'(m_err));
        check("frame_cnt", g, 64'(fcnt), 64'(16'(n_cmp / cpf)));
      end
      if (ack) begin
        ack = 1'b0;
        ack_wait = $urandom_range(ack_max, 0);
      end
      if (req) begin
        if (ack_wait == 0) begin
          ack = 1'b1;
          acc_log.push_back(data);
        end else begin
          ack_wait--;
        end
      end
      rd_last = 1'b0;
      if (inject) begin
        rd_last = 1'b1;
      end else if (due_q.size() > 0 && due_q[0] <= lane_cyc + 1) begin
        rd_last = 1'b1;
        void'(due_q.pop_front());
      end
    end
  end

  task automatic set_cfg(input logic [31:0] base, input logic [15:0] body, input logic [15:0] tail,
                         input logic [15:0] stride, input logic [15:0] bnum, input logic [15:0] loopn);
    cfg_base = base; cfg_body = body; cfg_tail = tail;
    cfg_stride = stride; cfg_bnum = bnum; cfg_loop = loopn;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 tx_start = 1'b1;
    @(posedge clk); #1 tx_start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((g_lane[0].active || g_lane[1].active ||
            g_lane[0].due_q.size() != 0 || g_lane[1].due_q.size() != 0) && k < budget) begin
      @(posedge clk);
      k++;
    end
    check("idle_timeout", 0, 64'(k < budget), 64'(1));
    repeat (2) @(posedge clk);
  endtask

  task automatic stop_after(input longint n_cmds, input int budget);
    int k = 0;
    while (g_lane[0].n_iss < n_cmds && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("stop_timeout", 0, 64'(k < budget), 64'(1));
    tx_stop = 1'b1;
    @(posedge clk); #1 tx_stop = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int b;
    @(posedge clk); #1 chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_busy", 0, 64'(g_lane[0].busy), 64'(0));
    check("reset_req", 0, 64'(g_lane[0].req), 64'(0));
    check("reset_data", 0, 64'(g_lane[0].data), 64'(0));
    check("reset_frame_cnt", 0, 64'(g_lane[0].fcnt), 64'(0));

    // 1: three bodies plus tail, single frame, immediate ack
    ack_max = 0; lat_min = 1; lat_max = 6;
    b = g_lane[0].acc_log.size();
    set_cfg(32'h1000_0000, 16'd870, 16'd100, 16'd0, 16'd3, 16'd1);
    pulse_start();
    wait_idle(2000);
    check("t1_cmd0", 0, 64'(g_lane[0].acc_log[b]),   64'({32'h1000_0000, 16'd870}));
    check("t1_cmd1", 0, 64'(g_lane[0].acc_log[b+1]), 64'({32'h1000_0366, 16'd870}));
    check("t1_cmd2", 0, 64'(g_lane[0].acc_log[b+2]), 64'({32'h1000_06CC, 16'd870}));
    check("t1_tail", 0, 64'(g_lane[0].acc_log[b+3]), 64'({32'h1000_0A32, 16'd100}));
    check("t1_frame_cnt", 0, 64'(g_lane[0].fcnt), 64'(1));

    // 2: no tail, stride 1024, three frames
    ack_max = 2; lat_max = 10;
    b = g_lane[0].acc_log.size();
    set_cfg(32'h2000_0000, 16'd256, 16'd0, 16'd1024, 16'd2, 16'd3);
    pulse_start();
    wait_idle(2000);
    check("t2_cmd3", 0, 64'(g_lane[0].acc_log[b+3]), 64'({32'h2000_0400, 16'd256}));
    check("t2_cmd4", 0, 64'(g_lane[0].acc_log[b+4]), 64'({32'h2000_0000, 16'd256}));
    check("t2_ncmds", 0, 64'(g_lane[0].acc_log.size() - b), 64'(6));
    check("t2_frame_cnt", 0, 64'(g_lane[0].fcnt), 64'(3));

    // 3: continuous, stop in the middle of frame 2
    b = g_lane[0].acc_log.size();
    set_cfg(32'h3000_0000, 16'd64, 16'd50, 16'd0, 16'd3, 16'd0);
    pulse_start();
    stop_after(5, 2000);
    wait_idle(2000);
    check("t3_ncmds", 0, 64'(g_lane[0].acc_log.size() - b), 64'(8));
    check("t3_frame_cnt", 0, 64'(g_lane[0].fcnt), 64'(2));

    // 4: slow ack, long completion latency
    ack_max = 5; lat_min = 5; lat_max = 20;
    set_cfg(32'h4000_0000, 16'd32, 16'd8, 16'd0, 16'd2, 16'd2);
    pulse_start();
    wait_idle(4000);

    // 5: abort with two reads in flight, then restart
    ack_max = 0; lat_min = 8; lat_max = 20;
    set_cfg(32'h5000_0000, 16'd16, 16'd0, 16'd0, 16'd4, 16'd0);
    pulse_start();
    begin
      int k = 0;
      while ((g_lane[0].n_iss - g_lane[0].n_cmp) != 2 && k < 200) begin
        @(negedge clk); k++;
      end
      check("t5_reach_two", 0, 64'(k < 200), 64'(1));
    end
    soft_rst = 1'b1;
    @(posedge clk); #1 soft_rst = 1'b0;
    @(negedge clk);
    check("t5_req_after_abort", 0, 64'(g_lane[0].req), 64'(0));
    check("t5_busy_after_abort", 0, 64'(g_lane[0].busy), 64'(0));
    wait_idle(2000);
    lat_min = 1; lat_max = 6;
    b = g_lane[0].acc_log.size();
    cfg_loop = 16'd1;
    pulse_start();
    wait_idle(2000);
    check("t5_restart_base", 0, 64'(g_lane[0].acc_log[b]), 64'({32'h5000_0000, 16'd16}));

    // 6: empty config, idle spurious completion, address wrap
    set_cfg(32'h6000_0000, 16'd16, 16'd0, 16'd0, 16'd0, 16'd1);
    @(posedge clk); #1 tx_start = 1'b1;
    @(posedge clk); #1 tx_start = 1'b0;
    @(negedge clk);
    check("t6_cfg_err", 0, 64'(g_lane[0].err), 64'(1));
    check("t6_cfg_no_busy", 0, 64'(g_lane[0].busy), 64'(0));
    repeat (2) @(posedge clk);
    #1 inject = 1'b1;
    @(posedge clk); #1 inject = 1'b0;
    @(negedge clk);
    check("t6_spurious_err", 0, 64'(g_lane[0].err), 64'(1));
    b = g_lane[0].acc_log.size();
    set_cfg(32'hFFFF_FF00, 16'h0080, 16'd0, 16'h0200, 16'd2, 16'd1);
    pulse_start();
    wait_idle(2000);
    check("t6_wrap_addr", 0, 64'(g_lane[0].acc_log[b+1]), 64'({32'h0000_0100, 16'h0080}));

    // Randomised jobs
    for (int r = 0; r < 10; r++) begin
      ack_max = $urandom_range(4, 0);
      lat_min = 1;
      lat_max = $urandom_range(14, 1);
      set_cfg($urandom, 16'($urandom_range(400, 1)),
              ($urandom_range(1, 0) == 1) ? 16'($urandom_range(300, 1)) : 16'd0,
              ($urandom_range(1, 0) == 1) ? 16'($urandom_range(4096, 1)) : 16'd0,
              16'($urandom_range(4, 0)), 16'($urandom_range(3, 0)));
      pulse_start();
      if (cfg_loop == 16'd0 && g_lane[0].active)
        stop_after(longint'($urandom_range(12, 0)), 3000);
      wait_idle(4000);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
